// File: rtl/err_loc_collector.sv
// err_loc_collector: reassembles a serialized error-location stream into a
// parallel slot bank with an error count, then holds it behind a done/ack
// handshake. Malformed words (too many beats, sentinel after the first beat)
// are flagged through o_fmt_err.
// Optional build macro: ERR_LOC_DUP_CHK_EN flags a beat that repeats a filled slot.
module err_loc_collector #(
   parameter int unsigned LOC_W      = 10,
   parameter int unsigned MAX_ERR    = 6,
   parameter int unsigned MAX_ERR_M0 = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_mode,
   input  logic                     i_valid,
   input  logic [LOC_W-1:0]         i_err_loc,
   input  logic                     i_ack,
   output logic [MAX_ERR*LOC_W-1:0] o_locs,
   output logic [2:0]               o_num_err,
   output logic                     o_done,
   output logic                     o_fmt_err,
   output logic                     o_drop
);

   typedef enum logic {S_IDLE, S_COLLECT} state_t;

   localparam logic [LOC_W-1:0] SENTINEL = '1;
   localparam logic [2:0]       LIMIT_M1 = 3'(MAX_ERR);
   localparam logic [2:0]       LIMIT_M0 = 3'(MAX_ERR_M0);

   state_t                     state_q, state_d;
   logic [MAX_ERR*LOC_W-1:0]   work_locs_q, work_locs_d;
   logic [2:0]                 work_cnt_q, work_cnt_d;
   logic [2:0]                 work_lim_q, work_lim_d;
   logic                       work_empty_q, work_empty_d;
   logic                       work_fmt_q, work_fmt_d;
   logic [MAX_ERR*LOC_W-1:0]   locs_q, locs_d;
   logic [2:0]                 num_q, num_d;
   logic                       done_q, done_d;
   logic                       fmt_q, fmt_d;
   logic                       drop_q, drop_d;

   // State, work bank and published result registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         work_locs_q  <= '1;
         work_cnt_q   <= '0;
         work_lim_q   <= LIMIT_M0;
         work_empty_q <= 1'b0;
         work_fmt_q   <= 1'b0;
         locs_q       <= '1;
         num_q        <= '0;
         done_q       <= 1'b0;
         fmt_q        <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         work_locs_q  <= work_locs_d;
         work_cnt_q   <= work_cnt_d;
         work_lim_q   <= work_lim_d;
         work_empty_q <= work_empty_d;
         work_fmt_q   <= work_fmt_d;
         locs_q       <= locs_d;
         num_q        <= num_d;
         done_q       <= done_d;
         fmt_q        <= fmt_d;
         drop_q       <= drop_d;
      end
   end

   // Next-state: collect beats into the work bank, publish on the first idle cycle.
   always_comb begin
      logic publish;
      publish      = 1'b0;
      state_d      = state_q;
      work_locs_d  = work_locs_q;
      work_cnt_d   = work_cnt_q;
      work_lim_d   = work_lim_q;
      work_empty_d = work_empty_q;
      work_fmt_d   = work_fmt_q;
      locs_d       = locs_q;
      num_d        = num_q;
      done_d       = done_q;
      fmt_d        = fmt_q;
      drop_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               work_lim_d  = i_mode ? LIMIT_M1 : LIMIT_M0;
               work_locs_d = '1;
               work_fmt_d  = 1'b0;
               if (i_err_loc == SENTINEL) begin
                  work_cnt_d   = '0;
                  work_empty_d = 1'b1;
               end else begin
                  work_locs_d[0 +: LOC_W] = i_err_loc;
                  work_cnt_d   = 3'd1;
                  work_empty_d = 1'b0;
               end
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (i_valid) begin
               if (work_empty_q || (i_err_loc == SENTINEL) || (work_cnt_q == work_lim_q)) begin
                  work_fmt_d = 1'b1;
               end else begin
                  for (int unsigned k = 0; k < MAX_ERR; k++) begin
                     if (3'(k) == work_cnt_q) work_locs_d[k*LOC_W +: LOC_W] = i_err_loc;
`ifdef ERR_LOC_DUP_CHK_EN
                     if ((3'(k) < work_cnt_q) && (work_locs_q[k*LOC_W +: LOC_W] == i_err_loc))
                        work_fmt_d = 1'b1;
`endif
                  end
                  work_cnt_d = work_cnt_q + 3'd1;
               end
            end else begin
               publish = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Publishing wins over a same-cycle ack; an unacked result being replaced is a drop.
      if (publish) begin
         locs_d = work_locs_q;
         num_d  = work_cnt_q;
         fmt_d  = work_fmt_q;
         done_d = 1'b1;
         drop_d = done_q & ~i_ack;
      end else if (done_q && i_ack) begin
         done_d = 1'b0;
      end
   end

   assign o_locs    = locs_q;
   assign o_num_err = num_q;
   assign o_done    = done_q;
   assign o_fmt_err = fmt_q;
   assign o_drop    = drop_q;

endmodule

// File: tb/tb_err_loc_collector.sv
// Scoreboard bench for err_loc_collector: stimulus pushes expected results
// computed from a list-based reference model; a negedge monitor pops them.
module tb_err_loc_collector;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_mode;
   logic        i_valid;
   logic [9:0]  i_err_loc;
   logic        i_ack;
   logic [59:0] o_locs;
   logic [2:0]  o_num_err;
   logic        o_done;
   logic        o_fmt_err;
   logic        o_drop;

   err_loc_collector #(.LOC_W(10), .MAX_ERR(6), .MAX_ERR_M0(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_valid(i_valid),
      .i_err_loc(i_err_loc), .i_ack(i_ack), .o_locs(o_locs), .o_num_err(o_num_err),
      .o_done(o_done), .o_fmt_err(o_fmt_err), .o_drop(o_drop)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [59:0] locs;
      logic [2:0]  num;
      logic        fmt;
      logic        drop;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   held   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: list of accepted locations built from the word's beats.
   function automatic exp_t model(input bit mode, input int unsigned beats[$], input bit drop);
      exp_t        e;
      int unsigned lim;
      int unsigned got[$];
      bit          fmt;
      lim = mode ? 6 : 4;
      fmt = 0;
      got = {};
      for (int i = 0; i < beats.size(); i++) begin
         if (i == 0) begin
            if (beats[0] != 1023) got.push_back(beats[0]);
         end else if (beats[0] == 1023 || beats[i] == 1023 || got.size() == lim) begin
            fmt = 1;
         end else begin
`ifdef ERR_LOC_DUP_CHK_EN
            foreach (got[j]) if (got[j] == beats[i]) fmt = 1;
`endif
            got.push_back(beats[i]);
         end
      end
      e.locs = '1;
      foreach (got[j]) e.locs[j*10 +: 10] = got[j][9:0];
      e.num  = 3'(got.size());
      e.fmt  = fmt;
      e.drop = drop;
      return e;
   endfunction

   task automatic cyc(input bit v, input logic [9:0] loc, input bit m, input bit a);
      i_valid   = v;
      i_err_loc = loc;
      i_mode    = m;
      i_ack     = a;
      @(posedge i_clk);
      #1;
   endtask

   // Beats, then one idle cycle on whose closing edge the result publishes.
   task automatic send_word(input bit mode, input int unsigned beats[$], input bit ack_pub);
      for (int i = 0; i < beats.size(); i++)
         cyc(1'b1, beats[i][9:0], (i == 0) ? mode : 1'($urandom), 1'b0);
      sb.push_back(model(mode, beats, held && !ack_pub));
      cyc(1'b0, 10'($urandom), 1'($urandom), ack_pub);
      held = 1;
      chk("done_rise", {63'b0, o_done}, 64'd1);
   endtask

   task automatic do_ack();
      cyc(1'b0, 10'd0, 1'b0, 1'b1);
      held = 0;
      chk("done_clear", {63'b0, o_done}, 64'd0);
   endtask

   // Monitor: a new result is present when done is set and either it just rose,
   // the previous cycle carried an ack (so it would have cleared), or a drop pulses.
   logic        pd = 1'b0, pa = 1'b0;
   logic [59:0] last_locs;
   logic [2:0]  last_num;
   logic        last_fmt;
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         pd = 1'b0;
         pa = 1'b0;
      end else begin
         if (o_done && (!pd || pa || o_drop)) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got num=%0d drop=%0b expected no result", o_num_err, o_drop);
            end else begin
               e = sb.pop_front();
               chk("locs", {4'b0, o_locs}, {4'b0, e.locs});
               chk("num_err", {61'b0, o_num_err}, {61'b0, e.num});
               chk("fmt_err", {63'b0, o_fmt_err}, {63'b0, e.fmt});
               chk("drop", {63'b0, o_drop}, {63'b0, e.drop});
            end
            last_locs = o_locs;
            last_num  = o_num_err;
            last_fmt  = o_fmt_err;
         end else if (o_done) begin
            chk("hold_locs", {4'b0, o_locs}, {4'b0, last_locs});
            chk("hold_num", {61'b0, o_num_err}, {61'b0, last_num});
            chk("hold_fmt", {63'b0, o_fmt_err}, {63'b0, last_fmt});
            chk("hold_drop", {63'b0, o_drop}, 64'd0);
         end else begin
            chk("idle_drop", {63'b0, o_drop}, 64'd0);
         end
         pd = o_done;
         pa = i_ack;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned q[$];
      int unsigned n, r, p;
      bit          m;
      i_rst = 1'b1; i_mode = 1'b0; i_valid = 1'b0; i_err_loc = '0; i_ack = 1'b0;
      #2;
      chk("rst_locs", {4'b0, o_locs}, {4'b0, {60{1'b1}}});
      chk("rst_num", {61'b0, o_num_err}, 64'd0);
      chk("rst_done", {63'b0, o_done}, 64'd0);
      chk("rst_fmt", {63'b0, o_fmt_err}, 64'd0);
      chk("rst_drop", {63'b0, o_drop}, 64'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      cyc(1'b0, 10'd0, 1'b0, 1'b0);

      q = {1023};                       send_word(1'b0, q, 1'b0); do_ack();
      q = {5, 77, 300, 1000, 12, 640};  send_word(1'b1, q, 1'b0);
      repeat (3) cyc(1'b0, 10'd0, 1'b0, 1'b0);
      chk("done_held", {63'b0, o_done}, 64'd1);
      do_ack();
      q = {1, 2, 3, 4, 5};              send_word(1'b0, q, 1'b0); do_ack();
      q = {200, 200};                   send_word(1'b1, q, 1'b0); do_ack();
      q = {7};                          send_word(1'b0, q, 1'b0);
      q = {8, 1023, 9};                 send_word(1'b1, q, 1'b1); do_ack();
      q = {9, 10};                      send_word(1'b0, q, 1'b0);
      q = {33};                         send_word(1'b0, q, 1'b0);

      // Reset in the middle of a word while a result is held.
      cyc(1'b1, 10'd1, 1'b1, 1'b0);
      cyc(1'b1, 10'd2, 1'b0, 1'b0);
      i_valid = 1'b1; i_err_loc = 10'd3;
      #2;
      i_rst = 1'b1; i_valid = 1'b0;
      #1;
      chk("mid_rst_locs", {4'b0, o_locs}, {4'b0, {60{1'b1}}});
      chk("mid_rst_num", {61'b0, o_num_err}, 64'd0);
      chk("mid_rst_done", {63'b0, o_done}, 64'd0);
      chk("mid_rst_fmt", {63'b0, o_fmt_err}, 64'd0);
      chk("mid_rst_drop", {63'b0, o_drop}, 64'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      held  = 0;
      cyc(1'b0, 10'd0, 1'b0, 1'b0);
      q = {44};                         send_word(1'b0, q, 1'b0); do_ack();

      for (int w = 0; w < 80; w++) begin
         n = $urandom_range(1, 8);
         q = {};
         for (int b = 0; b < n; b++) begin
            r = $urandom_range(0, 9);
            if (r == 0) q.push_back(1023);
            else if (r == 1 && q.size() > 0) q.push_back(q[$urandom_range(0, q.size() - 1)]);
            else q.push_back($urandom_range(0, 1022));
         end
         m = 1'($urandom);
         p = $urandom_range(0, 2);
         send_word(m, q, p == 1);
         if (p == 2) do_ack();
         repeat ($urandom_range(0, 2)) cyc(1'b0, 10'($urandom), 1'($urandom), 1'b0);
      end

      if (held) do_ack();
      repeat (3) cyc(1'b0, 10'd0, 1'b0, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
